// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types and defaults for the shared-ALU controller
package alu_share_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    OP_ADDC    = 3'd0,
    OP_ADDHALF = 3'd1,
    OP_MAX     = 3'd2,
    OP_TRIPLE  = 3'd3,
    OP_AND     = 3'd4,
    OP_OR      = 3'd5,
    OP_NOT     = 3'd6,
    OP_ZERO    = 3'd7
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational opcode decode and arithmetic with sign/zero flags
module alu_core
  import alu_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       opc_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] f_o,
  output logic             neg_o,
  output logic             zer_o
);

  // Opcode decode; every result is truncated to WIDTH bits (modulo 2^WIDTH)
  always_comb begin
    f_o = '0;
    case (opc_e'(opc_i))
      OP_ADDC:    f_o = m_i + n_i + WIDTH'(c_i);
      OP_ADDHALF: f_o = m_i + (n_i >> 1);
      OP_MAX:     f_o = ($signed(m_i) > $signed(n_i)) ? m_i : n_i;
      OP_TRIPLE:  f_o = (m_i << 1) + m_i;
      OP_AND:     f_o = m_i & n_i;
      OP_OR:      f_o = m_i | n_i;
      OP_NOT:     f_o = ~m_i;
      OP_ZERO:    f_o = '0;
      default:    f_o = '0;
    endcase
  end

  assign neg_o = f_o[WIDTH-1];
  assign zer_o = (f_o == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin two-requester controller sharing one ALU
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][2:0]            req_opc,
  input  logic [1:0][WIDTH-1:0]      req_m,
  input  logic [1:0][WIDTH-1:0]      req_n,
  input  logic [1:0]                 req_c,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [WIDTH-1:0]           rsp_f,
  output logic                       rsp_neg,
  output logic                       rsp_zer,
  output logic [1:0][CNT_W-1:0]      done_cnt,
  output logic                       busy
);

  state_e                  state_q, state_d;
  logic                    last_q;
  logic                    gnt_q;
  logic [2:0]              opc_q;
  logic [WIDTH-1:0]        m_q, n_q;
  logic                    c_q;
  logic [WIDTH-1:0]        rsp_f_q;
  logic                    rsp_neg_q, rsp_zer_q;
  logic [1:0][CNT_W-1:0]   cnt_q;

  logic                    win;
  logic                    accept;
  logic [WIDTH-1:0]        alu_f;
  logic                    alu_neg, alu_zer;

  // On a tie the requester that did not win last time gets the grant
  assign win    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign accept = rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00);

  assign req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .opc_i (opc_q),
    .m_i   (m_q),
    .n_i   (n_q),
    .c_i   (c_q),
    .f_o   (alu_f),
    .neg_o (alu_neg),
    .zer_o (alu_zer)
  );

  // Next-state: accept in IDLE, one EXEC cycle, hold RESP until the consumer takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, arbiter pointer, operand latches, response registers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      opc_q     <= '0;
      m_q       <= '0;
      n_q       <= '0;
      c_q       <= 1'b0;
      rsp_f_q   <= '0;
      rsp_neg_q <= 1'b0;
      rsp_zer_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= win;
        gnt_q  <= win;
        opc_q  <= req_opc[win];
        m_q    <= req_m[win];
        n_q    <= req_n[win];
        c_q    <= req_c[win];
      end
      if (state_q == ST_EXEC) begin
        rsp_f_q   <= alu_f;
        rsp_neg_q <= alu_neg;
        rsp_zer_q <= alu_zer;
      end
      if (state_q == ST_RESP && rsp_ready) begin
        cnt_q[gnt_q] <= cnt_q[gnt_q] + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = gnt_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_zer   = rsp_zer_q;
  assign done_cnt  = cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 2;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][2:0]       req_opc;
  logic [1:0][WIDTH-1:0] req_m;
  logic [1:0][WIDTH-1:0] req_n;
  logic [1:0]            req_c;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [WIDTH-1:0]      rsp_f;
  logic                  rsp_neg;
  logic                  rsp_zer;
  logic [1:0][CNT_W-1:0] done_cnt;
  logic                  busy;

  int n_checks;
  int n_fail;
  int cnt_m [2];

  alu_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opc   (req_opc),
    .req_m     (req_m),
    .req_n     (req_n),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f),
    .rsp_neg   (rsp_neg),
    .rsp_zer   (rsp_zer),
    .done_cnt  (done_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [2:0] opc, input logic [15:0] m,
                         input logic [15:0] n, input logic c);
    req_opc[r]   = opc;
    req_m[r]     = m;
    req_n[r]     = n;
    req_c[r]     = c;
    req_valid[r] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from the IDLE cycle through the handshake; bp = RESP stall cycles
  task automatic run_op(input string tag, input int w, input logic [1:0] after_valid,
                        input logic [15:0] ef, input logic en, input logic ez, input int bp);
    logic [15:0] f_seen;
    #1;
    check_eq({tag, "_ready"}, 32'(req_ready), (w == 1) ? 32'd2 : 32'd1);
    rsp_ready = (bp == 0);
    @(posedge clk);
    #1;
    req_valid = after_valid;
    check_eq({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_exec_rdy"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_exec_vld"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_f"}, 32'(rsp_f), 32'(ef));
    check_eq({tag, "_neg"}, 32'(rsp_neg), 32'(en));
    check_eq({tag, "_zer"}, 32'(rsp_zer), 32'(ez));
    check_eq({tag, "_id"}, 32'(rsp_id), 32'(w));
    f_seen = rsp_f;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_bp_vld"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_bp_f"}, 32'(rsp_f), 32'(f_seen));
      check_eq({tag, "_bp_rdy"}, 32'(req_ready), 32'd0);
      check_eq({tag, "_bp_cnt"}, 32'(done_cnt[w]), 32'(cnt_m[w]));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_m[w] = (cnt_m[w] + 1) % 4;
    check_eq({tag, "_cnt0"}, 32'(done_cnt[0]), 32'(cnt_m[0]));
    check_eq({tag, "_cnt1"}, 32'(done_cnt[1]), 32'(cnt_m[1]));
    check_eq({tag, "_done_vld"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cnt_m[0]  = 0;
    cnt_m[1]  = 0;
    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_opc   = '0;
    req_m     = '0;
    req_n     = '0;
    req_c     = '0;
    rsp_ready = 1'b1;

    #12;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_vld", 32'(rsp_valid), 32'd0);
    check_eq("rst_id", 32'(rsp_id), 32'd0);
    check_eq("rst_f", 32'(rsp_f), 32'd0);
    check_eq("rst_neg", 32'(rsp_neg), 32'd0);
    check_eq("rst_zer", 32'(rsp_zer), 32'd0);
    check_eq("rst_cnt", 32'(done_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request: 5 + 7 + 1
    set_req(0, 3'd0, 16'd5, 16'd7, 1'b1);
    run_op("single", 0, 2'b00, 16'd13, 1'b0, 1'b0, 0);

    // Simultaneous requests from a fresh pointer: 0,1,0,1
    do_reset();
    set_req(0, 3'd4, 16'h00FF, 16'h0F0F, 1'b0);
    set_req(1, 3'd6, 16'h00FF, 16'h0000, 1'b0);
    run_op("tie_a", 0, 2'b11, 16'h000F, 1'b0, 1'b0, 0);
    run_op("tie_b", 1, 2'b11, 16'hFF00, 1'b1, 1'b0, 0);
    run_op("tie_c", 0, 2'b11, 16'h000F, 1'b0, 1'b0, 0);
    run_op("tie_d", 1, 2'b00, 16'hFF00, 1'b1, 1'b0, 0);

    // Backpressure on requester 1 while requester 0 waits with opcode 7
    set_req(1, 3'd0, 16'd1, 16'd2, 1'b0);
    req_opc[0] = 3'd7;
    req_m[0]   = 16'h1234;
    req_valid  = 2'b10;
    run_op("bp", 1, 2'b01, 16'd3, 1'b0, 1'b0, 5);
    run_op("zero", 0, 2'b00, 16'h0000, 1'b0, 1'b1, 0);

    // Arithmetic edges
    set_req(0, 3'd2, 16'h8000, 16'h0001, 1'b0);
    run_op("max_sgn", 0, 2'b00, 16'h0001, 1'b0, 1'b0, 0);
    set_req(1, 3'd3, 16'h4000, 16'h0000, 1'b0);
    run_op("triple", 1, 2'b00, 16'hC000, 1'b1, 1'b0, 0);
    set_req(0, 3'd1, 16'h0000, 16'hFFFF, 1'b0);
    run_op("addhalf", 0, 2'b00, 16'h7FFF, 1'b0, 1'b0, 0);
    set_req(1, 3'd5, 16'h00F0, 16'h0F00, 1'b0);
    run_op("or", 1, 2'b00, 16'h0FF0, 1'b0, 1'b0, 0);
    set_req(0, 3'd0, 16'hFFFF, 16'h0000, 1'b1);
    run_op("addc_wrap", 0, 2'b00, 16'h0000, 1'b0, 1'b1, 0);
    set_req(1, 3'd2, 16'hFFFE, 16'h0003, 1'b0);
    run_op("max_pos", 1, 2'b00, 16'h0003, 1'b0, 1'b0, 0);

    // Reset while an operation is in EXEC
    set_req(0, 3'd0, 16'd100, 16'd200, 1'b0);
    #1;
    check_eq("rexec_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check_eq("rexec_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rexec_vld", 32'(rsp_valid), 32'd0);
    check_eq("rexec_busy", 32'(busy), 32'd0);
    check_eq("rexec_cnt", 32'(done_cnt), 32'd0);
    check_eq("rexec_f", 32'(rsp_f), 32'd0);
    #1;
    rst_n = 1'b1;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    @(posedge clk);
    #1;
    check_eq("rexec_idle_vld", 32'(rsp_valid), 32'd0);
    set_req(0, 3'd0, 16'd100, 16'd200, 1'b0);
    run_op("after_rst", 0, 2'b00, 16'd300, 1'b0, 1'b0, 0);

    // Counter wrap: five completions from requester 1 with a 2-bit counter
    do_reset();
    set_req(1, 3'd4, 16'hF00F, 16'hFF00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      req_valid[1] = 1'b1;
      run_op("wrap", 1, 2'b00, 16'hF000, 1'b1, 1'b0, 0);
    end
    check_eq("wrap_final1", 32'(done_cnt[1]), 32'd1);
    check_eq("wrap_final0", 32'(done_cnt[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
